// File: rtl/biquad_seq_ctrl_pkg.sv
// Shared selector codes, state encodings and helpers for the biquad sequencer.
// The datapath decodes the selector codes, so their values must stay fixed.
package biquad_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_MA1  = 4'd2,
    ST_MA2  = 4'd3,
    ST_STF  = 4'd4,
    ST_MB0  = 4'd5,
    ST_MB1  = 4'd6,
    ST_MB2  = 4'd7,
    ST_STY  = 4'd8,
    ST_UPD  = 4'd9
  } state_t;

  localparam logic [2:0] SEL_S_ZERO = 3'd0;
  localparam logic [2:0] SEL_S_A1   = 3'd1;
  localparam logic [2:0] SEL_S_A2   = 3'd2;
  localparam logic [2:0] SEL_S_B0   = 3'd3;
  localparam logic [2:0] SEL_S_B1   = 3'd4;
  localparam logic [2:0] SEL_S_B2   = 3'd5;

  localparam logic [1:0] SEL_C_ZERO = 2'd0;
  localparam logic [1:0] SEL_C_FK1  = 2'd1;
  localparam logic [1:0] SEL_C_FK2  = 2'd2;
  localparam logic [1:0] SEL_C_FK   = 2'd3;

  localparam logic [1:0] SEL_Z_ZERO = 2'd0;
  localparam logic [1:0] SEL_Z_UK   = 2'd1;
  localparam logic [1:0] SEL_Z_YK   = 2'd2;

  // Wide enough for the largest legal multiplier latency (7).
  localparam int STEP_CNT_W = 3;

endpackage

// File: rtl/biquad_seq_ctrl_step_timer.sv
// Per-step wait counter: counts cycles spent in a MAC state and flags the last one.
// Holding clr outside MAC states guarantees every MAC state is entered with a count of 0.
module biquad_seq_ctrl_step_timer #(
  parameter int CNT_W   = 3,
  parameter int MUL_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == LAST_CNT);

endmodule

// File: rtl/biquad_seq_ctrl.sv
// Direct form II biquad sequencer: drives selector codes and register enables for a
// serial MAC datapath, one output sample per accepted start, with a sticky overrun flag.
module biquad_seq_ctrl
  import biquad_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clr_ovr,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [1:0] controlZ,
  output logic       acc_load,
  output logic       acc_en,
  output logic       fk_en,
  output logic       yk_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  localparam int CNT_W = STEP_CNT_W;

  state_t state_q;
  state_t state_d;
  logic   ovr_q;
  logic   ovr_d;
  logic   mac;
  logic   term;
  logic   step_clr;

  assign step_clr = ~mac | term;

  biquad_seq_ctrl_step_timer #(
    .CNT_W  (CNT_W),
    .MUL_LAT(MUL_LAT)
  ) u_step_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (step_clr),
    .term (term)
  );

  // Outputs decode from registered state and counter only, so start never reaches them.
  always_comb begin
    state_d  = state_q;
    controlS = SEL_S_ZERO;
    controlC = SEL_C_ZERO;
    controlZ = SEL_Z_ZERO;
    acc_load = 1'b0;
    fk_en    = 1'b0;
    yk_en    = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mac      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        controlZ = SEL_Z_UK;
        acc_load = 1'b1;
        state_d  = ST_MA1;
      end
      ST_MA1: begin
        busy     = 1'b1;
        mac      = 1'b1;
        controlS = SEL_S_A1;
        controlC = SEL_C_FK1;
        if (term) state_d = ST_MA2;
      end
      ST_MA2: begin
        busy     = 1'b1;
        mac      = 1'b1;
        controlS = SEL_S_A2;
        controlC = SEL_C_FK2;
        if (term) state_d = ST_STF;
      end
      ST_STF: begin
        // fk captures the finished sum while the accumulator reloads zero on the same edge.
        busy     = 1'b1;
        fk_en    = 1'b1;
        acc_load = 1'b1;
        state_d  = ST_MB0;
      end
      ST_MB0: begin
        busy     = 1'b1;
        mac      = 1'b1;
        controlS = SEL_S_B0;
        controlC = SEL_C_FK;
        if (term) state_d = ST_MB1;
      end
      ST_MB1: begin
        busy     = 1'b1;
        mac      = 1'b1;
        controlS = SEL_S_B1;
        controlC = SEL_C_FK1;
        if (term) state_d = ST_MB2;
      end
      ST_MB2: begin
        busy     = 1'b1;
        mac      = 1'b1;
        controlS = SEL_S_B2;
        controlC = SEL_C_FK2;
        if (term) state_d = ST_STY;
      end
      ST_STY: begin
        busy    = 1'b1;
        yk_en   = 1'b1;
        state_d = ST_UPD;
      end
      ST_UPD: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        controlZ = SEL_Z_YK;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    acc_en = mac & term;
  end

  // A start while busy is an overrun; it outranks a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (start && busy) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ovr = ovr_q;

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Directed bench for the biquad sequencer: cycle traces at MUL_LAT 0 and 2, overrun,
// back-to-back starts, mid-sequence reset, and an impulse response through a datapath model.
module tb_biquad_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, clr0, start2, clr2;
  logic [2:0] s0, s2;
  logic [1:0] c0, z0, c2, z2;
  logic       ld0, ae0, fe0, ye0, sh0, bz0, dn0, ov0;
  logic       ld2, ae2, fe2, ye2, sh2, bz2, dn2, ov2;
  logic [14:0] outs0, outs2;

  biquad_seq_ctrl #(.MUL_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clr_ovr(clr0),
    .controlS(s0), .controlC(c0), .controlZ(z0),
    .acc_load(ld0), .acc_en(ae0), .fk_en(fe0), .yk_en(ye0), .shift_en(sh0),
    .busy(bz0), .done(dn0), .ovr(ov0)
  );

  biquad_seq_ctrl #(.MUL_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .clr_ovr(clr2),
    .controlS(s2), .controlC(c2), .controlZ(z2),
    .acc_load(ld2), .acc_en(ae2), .fk_en(fe2), .yk_en(ye2), .shift_en(sh2),
    .busy(bz2), .done(dn2), .ovr(ov2)
  );

  assign outs0 = {s0, c0, z0, ld0, ae0, fe0, ye0, sh0, bz0, dn0, ov0};
  assign outs2 = {s2, c2, z2, ld2, ae2, fe2, ye2, sh2, bz2, dn2, ov2};

  int total = 0;
  int bad   = 0;
  bit ovr_exp = 1'b0;
  int exp_done = 0;

  // Behavioural datapath driven by dut0: Q14 coefficients, round-half-up products.
  localparam longint A1 = 32702, A2 = -16318, B0 = 16351, B1 = -32702, B2 = 16351;
  longint uk = 0, acc = 0, fk = 0, f1 = 0, f2 = 0, yk = 0;
  int ye_cnt = 0, sh_cnt = 0, done_cnt = 0;

  function automatic longint coef(input logic [2:0] s);
    case (s)
      3'd1: return A1;
      3'd2: return A2;
      3'd3: return B0;
      3'd4: return B1;
      3'd5: return B2;
      default: return 0;
    endcase
  endfunction

  function automatic longint stv(input logic [1:0] c, input longint v1, input longint v2,
                                 input longint vf);
    case (c)
      2'd1: return v1;
      2'd2: return v2;
      2'd3: return vf;
      default: return 0;
    endcase
  endfunction

  function automatic longint rq(input longint p);
    return (p + 64'sd8192) >>> 14;
  endfunction

  always @(posedge clk) begin
    if (ld0) acc <= (z0 == 2'd1) ? uk : (z0 == 2'd2) ? yk : 0;
    else if (ae0) acc <= acc + rq(coef(s0) * stv(c0, f1, f2, fk));
    if (fe0) fk <= acc;
    if (ye0) begin
      yk <= acc;
      ye_cnt <= ye_cnt + 1;
    end
    if (sh0) begin
      f2 <= f1;
      f1 <= fk;
      sh_cnt <= sh_cnt + 1;
    end
    if (dn0) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] ev(input int s, input int c, input int z,
                                     input bit ld, input bit ae, input bit fe, input bit ye,
                                     input bit sh, input bit bz, input bit dn, input bit ov);
    return {s[2:0], c[1:0], z[1:0], ld, ae, fe, ye, sh, bz, dn, ov};
  endfunction

  // Bench state codes: 0 IDLE,1 LOAD,2 MA1,3 MA2,4 STF,5 MB0,6 MB1,7 MB2,8 STY,9 UPD
  function automatic logic [14:0] st_vec(input int st, input bit ae, input bit ov);
    case (st)
      0: return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ov);
      1: return ev(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, ov);
      2: return ev(1, 1, 0, 0, ae, 0, 0, 0, 1, 0, ov);
      3: return ev(2, 2, 0, 0, ae, 0, 0, 0, 1, 0, ov);
      4: return ev(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, ov);
      5: return ev(3, 3, 0, 0, ae, 0, 0, 0, 1, 0, ov);
      6: return ev(4, 1, 0, 0, ae, 0, 0, 0, 1, 0, ov);
      7: return ev(5, 2, 0, 0, ae, 0, 0, 0, 1, 0, ov);
      8: return ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, ov);
      9: return ev(0, 0, 2, 0, 0, 0, 0, 1, 1, 1, ov);
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one MUL_LAT=0 sequence on dut0 (start must already be high in IDLE);
  // masks give start/clr_ovr driven during busy cycle k (1..9).
  task automatic seq0(input logic [9:0] st_mask, input logic [9:0] clr_mask, input string tag);
    logic [9:0] ae_mask;
    ae_mask = 10'b0011101100;
    step();
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("%s_c%0d", tag, k), {17'd0, outs0}, {17'd0, st_vec(k, ae_mask[k], ovr_exp)});
      start0 = st_mask[k];
      clr0   = clr_mask[k];
      if (start0) ovr_exp = 1'b1;
      else if (clr0) ovr_exp = 1'b0;
      step();
    end
    exp_done++;
    $display("seq %s finished, ovr=%0b done_cnt=%0d", tag, ov0, done_cnt);
  endtask

  real a1r, a2r, b0r, b1r, b2r, fr, f1r, f2r, yr, dy;
  int  st_list[$];
  bit  ae_list[$];
  int  busy_cnt, ae_cnt, ye_snap, sh_snap;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; clr0 = 1'b0; start2 = 1'b0; clr2 = 1'b0;
    a1r = 32702.0 / 16384.0; a2r = -16318.0 / 16384.0;
    b0r = 16351.0 / 16384.0; b1r = -32702.0 / 16384.0; b2r = 16351.0 / 16384.0;
    f1r = 0.0; f2r = 0.0;

    repeat (2) step();
    chk("reset_outs0", {17'd0, outs0}, 32'd0);
    chk("reset_outs2", {17'd0, outs2}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", {17'd0, outs0}, {17'd0, st_vec(0, 0, 0)});

    // Impulse response, full trace checked on every sample
    for (int n = 0; n < 4; n++) begin
      uk = (n == 0) ? 64'sd16384 : 64'sd0;
      start0 = 1'b1;
      seq0(10'd0, 10'd0, $sformatf("smp%0d", n));
      chk($sformatf("smp%0d_idle", n), {17'd0, outs0}, {17'd0, st_vec(0, 0, ovr_exp)});
      fr  = real'(uk) + a1r * f1r + a2r * f2r;
      yr  = b0r * fr + b1r * f1r + b2r * f2r;
      f2r = f1r;
      f1r = fr;
      dy  = real'(yk) - yr;
      total++;
      assert (dy <= 1.0 && dy >= -1.0) else begin
        bad++;
        $error("FAIL yk%0d: observed=%0d expected=%f", n, yk, yr);
      end
      $display("sample %0d: yk=%0d ref=%f", n, yk, yr);
    end

    // MUL_LAT=2 trace on dut2
    st_list.push_back(1); ae_list.push_back(1'b0);
    for (int m = 2; m <= 7; m++) begin
      if (m == 4) begin
        st_list.push_back(4); ae_list.push_back(1'b0);
      end else begin
        for (int r = 0; r < 3; r++) begin
          st_list.push_back(m); ae_list.push_back(r == 2);
        end
      end
    end
    st_list.push_back(8); ae_list.push_back(1'b0);
    st_list.push_back(9); ae_list.push_back(1'b0);
    busy_cnt = 0; ae_cnt = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < st_list.size(); i++) begin
      chk($sformatf("ml2_c%0d", i + 1), {17'd0, outs2}, {17'd0, st_vec(st_list[i], ae_list[i], 0)});
      busy_cnt += int'(bz2);
      ae_cnt   += int'(ae2);
      step();
    end
    chk("ml2_idle", {17'd0, outs2}, 32'd0);
    chk("ml2_busy_len", busy_cnt, 19);
    chk("ml2_acc_en_cnt", ae_cnt, 5);
    $display("ml2 sequence: busy=%0d acc_en=%0d", busy_cnt, ae_cnt);

    // Overrun in MA2, then start+clr together in MB1 (set wins)
    start0 = 1'b1;
    seq0(10'b0001001000, 10'b0001000000, "ovr");
    chk("ovr_held", {17'd0, outs0}, {17'd0, st_vec(0, 0, 1)});
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    ovr_exp = 1'b0;
    chk("ovr_cleared", {17'd0, outs0}, {17'd0, st_vec(0, 0, 0)});

    // Back-to-back: start in UPD (overrun), held into IDLE, then held for a whole sequence
    start0 = 1'b1;
    seq0(10'b1000000000, 10'd0, "b2b_a");
    chk("b2b_idle_a", {17'd0, outs0}, {17'd0, st_vec(0, 0, 1)});
    seq0(10'b1111111110, 10'd0, "b2b_b");
    chk("b2b_idle_b", {17'd0, outs0}, {17'd0, st_vec(0, 0, 1)});
    seq0(10'd0, 10'd0, "b2b_c");
    chk("b2b_idle_c", {17'd0, outs0}, {17'd0, st_vec(0, 0, 1)});
    chk("done_count", done_cnt, exp_done);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    ovr_exp = 1'b0;
    chk("b2b_ovr_cleared", {31'd0, ov0}, 32'd0);

    // Reset asserted during MB0
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (4) step();
    chk("pre_rst_mb0", {17'd0, outs0}, {17'd0, st_vec(5, 1, 0)});
    ye_snap = ye_cnt;
    sh_snap = sh_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {17'd0, outs0}, 32'd0);
    step();
    chk("rst_held_outs", {17'd0, outs0}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("rst_idle_outs", {17'd0, outs0}, 32'd0);
    chk("rst_no_yk_en", ye_cnt, ye_snap);
    chk("rst_no_shift", sh_cnt, sh_snap);
    start0 = 1'b1;
    seq0(10'd0, 10'd0, "post_rst");
    chk("post_rst_idle", {17'd0, outs0}, {17'd0, st_vec(0, 0, 0)});
    chk("post_rst_done", done_cnt, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biquad_seq_ctrl.md
Name: biquad_seq_ctrl

Overview:
- Sequencer for the fixed-point second-order IIR (biquad) datapath, one output sample per accepted start.
- The datapath is a single serial multiply-accumulate fed by three selectors:
  - coefficient select: zero, a1, a2, b0, b1, b2
  - state select: zero, fk1, fk2, fk
  - preload select: zero, Uk, yk
- This block drives those selector codes plus the accumulator and register enables, in direct form II order:
  - fk = Uk + a1·fk1 + a2·fk2
  - yk = b0·fk + b1·fk1 + b2·fk2
  - then the delay line shifts.
- Sits between the sample-rate tick source and the datapath.

Parameters:
- MUL_LAT, 0: multiplier pipeline depth in cycles. Each MAC step lasts MUL_LAT+1 cycles. Legal range 0..7.
- CNT_W, 3: width of the step wait counter. Local, derived so that it holds MUL_LAT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to process the current Uk
- clr_ovr  in  1  clears the sticky overrun flag
- controlS  out  3  coefficient select: 0=zero, 1=a1, 2=a2, 3=b0, 4=b1, 5=b2
- controlC  out  2  state select: 0=zero, 1=fk1, 2=fk2, 3=fk
- controlZ  out  2  preload select: 0=zero, 1=Uk, 2=yk
- acc_load  out  1  accumulator <= preload value
- acc_en  out  1  accumulator <= accumulator + product
- fk_en  out  1  fk register <= accumulator
- yk_en  out  1  yk register <= accumulator
- shift_en  out  1  fk2 <= fk1 and fk1 <= fk, in the same cycle
- busy  out  1  high from LOAD through UPDATE
- done  out  1  one-cycle pulse in UPDATE
- ovr  out  1  sticky overrun flag

Behaviour:
- Reset:
  - clk, one clock domain. rst_n is asynchronous assert, active-low.
  - On reset, state = IDLE, wait counter = 0, every output = 0 (including ovr and all select codes).
  - Reset asserted mid-sequence aborts immediately. No enable may pulse after reset is asserted.
- States and per-state outputs (unlisted outputs are 0):
  - IDLE:
    - outputs: all 0
    - transition: start=1 -> LOAD
  - LOAD:
    - outputs: controlZ=1, acc_load=1
    - transition: -> MA1
  - MA1:
    - outputs: S=1, C=1
    - transition: -> MA2 after the wait rule
  - MA2:
    - outputs: S=2, C=2
    - transition: -> STF after the wait rule
  - STF:
    - outputs: fk_en=1, acc_load=1, controlZ=0
    - both act on the same edge: fk captures the old accumulator, and the accumulator clears.
    - transition: -> MB0
  - MB0:
    - outputs: S=3, C=3
    - transition: -> MB1 after the wait rule
  - MB1:
    - outputs: S=4, C=1
    - transition: -> MB2 after the wait rule
  - MB2:
    - outputs: S=5, C=2
    - transition: -> STY after the wait rule
  - STY:
    - outputs: yk_en=1
    - transition: -> UPD
  - UPD:
    - outputs: shift_en=1, controlZ=2, done=1
    - transition: -> IDLE
- Wait rule for MAC states (MA1, MA2, MB0, MB1, MB2):
  - On entry, the counter loads 0.
  - The selects are held constant for MUL_LAT+1 cycles.
  - acc_en=1 only in the final cycle, when counter == MUL_LAT; that is also when the state advances.
  - With MUL_LAT=0 each MAC state is 1 cycle with acc_en=1.
- Latency:
  - Busy length = 5·(MUL_LAT+1)+4 cycles (9 cycles for MUL_LAT=0).
  - done is asserted exactly busy-length-1 cycles after the first busy cycle.
  - A start sampled in IDLE makes busy rise on the next cycle.
- All outputs are registered, or decoded from registered state only. There is no combinational path from start to any output.
- Overrun:
  - start=1 while busy=1 (including the UPD cycle) is ignored and sets ovr=1 on the next edge.
  - clr_ovr=1 clears ovr.
  - Simultaneous clr_ovr and overrunning start: set wins.
- start held high:
  - every busy cycle counts as overrun;
  - the sequence restarts on the first IDLE cycle in which start=1.
- Illegal state encodings recover to IDLE on the next edge, with all outputs 0.

Decomposition:
- Shared constants in the common header:
  - selector codes SEL_S_ZERO/A1/A2/B0/B1/B2, SEL_C_ZERO/FK1/FK2/FK, SEL_Z_ZERO/UK/YK
  - state encodings
- One sub-module: step_timer. A CNT_W-bit counter with load-zero and a terminal flag (count == MUL_LAT).

Test Plan:
- Reset during MB0 with MUL_LAT=0 -> all outputs 0 within the same cycle; no shift_en or yk_en follows; state returns to IDLE; a later start runs a full 9-cycle sequence.
- MUL_LAT=0, one start pulse -> busy high for 9 cycles with this per-cycle {S,C,Z} trace:
  - {0,0,1} LOAD, {1,1,0} MA1, {2,2,0} MA2, {0,0,0} STF
  - {3,3,0} MB0, {4,1,0} MB1, {5,2,0} MB2, {0,0,0} STY, {0,0,2} UPD
  - acc_en in cycles 2, 3, 5, 6, 7; done in cycle 9.
- MUL_LAT=2, one start -> busy for 19 cycles; each MAC select pair held 3 cycles; acc_en only in each pair's third cycle (5 pulses total).
- End-to-end with a behavioural datapath model:
  - a1=32702, a2=-16318, b0=16351, b1=-32702, b2=16351 (F=14), Uk=16384 impulse then 0s
  - yk over 4 samples matches the double-precision biquad model within 1 LSB.
- Start pulsed during MA2, then start asserted together with clr_ovr during MB1 -> ovr=1 after the first, stays 1 (set wins); a lone clr_ovr later -> ovr=0; the current sequence completes unaffected.
- Back-to-back starts, one per cycle immediately after done -> the new sequence begins with LOAD one cycle after the IDLE-cycle start; no sample is lost; ovr reflects only the starts made while busy.
